// File: rtl/hilo_divide_unit.sv
// ============================================================================
// hilo_divide_unit
// ----------------------------------------------------------------------------
// Sequential HI/LO back-end for the MIPS datapath. Owns the architectural HI
// and LO registers, captures the ALU's 64-bit multiply product, performs
// DIV/DIVU with an iterative restoring divider (one quotient bit per cycle),
// and handles MTHI/MTLO writes.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   Start    in   one-cycle request, sampled only in IDLE
//   Op       in   00 DIV (signed), 01 DIVU, 10 MTHI, 11 MTLO
//   A        in   dividend / MTHI-MTLO source
//   B        in   divisor
//   Mult_Wr  in   capture ALU_Hi/ALU_Lo into HI/LO (IDLE, Start low)
//   ALU_Hi   in   product upper half
//   ALU_Lo   in   product lower half
//   Busy     out  divide in progress
//   Done     out  one-cycle pulse: HI/LO hold the divide result
//   DivZero  out  pulses with Done when the divisor was zero
//   HI, LO   out  architectural HI/LO registers
//
// Configuration:
//   HILO_FWD_EN  when defined, HI/LO combinationally bypass the value being
//                written this cycle by Mult_Wr or MTHI/MTLO. Divide results
//                are never bypassed.
// ============================================================================
module hilo_divide_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Mult_Wr,
    input  logic [WIDTH-1:0] ALU_Hi,
    input  logic [WIDTH-1:0] ALU_Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_quo_q, neg_rem_q, dz_q;
    logic             done_q, divzero_q;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic             idle, start_div, start_mt, mult_cap, b_zero, is_signed;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign idle      = (state_q == S_IDLE);
    assign start_div = idle && Start && !Op[1];
    assign start_mt  = idle && Start &&  Op[1];
    // Start has priority over a multiply write-back in the same cycle.
    assign mult_cap  = idle && !Start && Mult_Wr;
    assign b_zero    = (B == '0);
    assign is_signed = (Op == OP_DIV);

    // Magnitudes for the unsigned core; DIVU passes raw operands through.
    // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
    assign a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag = (is_signed && B[WIDTH-1]) ? -B : B;

    // ------------------------------------------------------------------
    // Restoring step: shift {rem, quo} left, trial-subtract the divisor.
    // The shifted remainder needs one extra bit because rem < divisor can
    // be as large as 2^WIDTH - 2.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [WIDTH-1:0] rem_step, quo_step;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr_q};
    assign fits     = !trial[WIDTH];
    assign rem_step = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], fits};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // the pre-edge value of every other register, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_div) state_d = b_zero ? S_FIN : S_DIV;
            S_DIV:  if (cnt_q == LAST_STEP) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. A divide-by-zero spends its single busy cycle in FIN.
    // ------------------------------------------------------------------
    always_comb begin
        Busy = (state_q == S_DIV) || ((state_q == S_FIN) && dz_q);
    end

    assign Done    = done_q;
    assign DivZero = divzero_q;

    // ------------------------------------------------------------------
    // Datapath: HI/LO and divider working registers
    // ------------------------------------------------------------------
    // NOTE: every register here, datapath included, is cleared by reset so a
    // divide aborted by rst_n leaves no residue and HI/LO read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_mt) begin
                        if (Op == OP_MTLO) lo_q <= A;
                        else               hi_q <= A;
                    end else if (start_div) begin
                        cnt_q <= '0;
                        if (b_zero) begin
                            // Preload the final values so FIN writes them
                            // unchanged: HI = A, LO = all ones.
                            rem_q     <= A;
                            quo_q     <= '1;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            dz_q      <= 1'b1;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= a_mag;
                            dvsr_q    <= b_mag;
                            neg_quo_q <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_rem_q <= is_signed && A[WIDTH-1];
                            dz_q      <= 1'b0;
                        end
                    end else if (mult_cap) begin
                        hi_q <= ALU_Hi;
                        lo_q <= ALU_Lo;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIN: begin
                    hi_q      <= neg_rem_q ? -rem_q : rem_q;
                    lo_q      <= neg_quo_q ? -quo_q : quo_q;
                    done_q    <= 1'b1;
                    divzero_q <= dz_q;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // HI/LO output view
    // ------------------------------------------------------------------
`ifdef HILO_FWD_EN
    always_comb begin
        HI = hi_q;
        LO = lo_q;
        if (start_mt) begin
            if (Op == OP_MTLO) LO = A;
            else               HI = A;
        end else if (mult_cap) begin
            HI = ALU_Hi;
            LO = ALU_Lo;
        end
    end
`else
    assign HI = hi_q;
    assign LO = lo_q;
`endif

endmodule

// File: doc/hilo_divide_unit.md
Name: hilo_divide_unit

Overview:
- Sequential HI/LO back-end for the MIPS datapath.
- Owns the architectural HI and LO registers.
- Captures the 64-bit product from the combinational ALU's Hi/Lo result bus on multiply write-back.
- Implements DIV/DIVU as an iterative restoring divider (the ALU has no divide), plus MTHI/MTLO writes; HI/LO outputs feed MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  one-cycle request; sampled only in IDLE
- Op  input  2  00 DIV (signed), 01 DIVU, 10 MTHI, 11 MTLO
- A  input  WIDTH  dividend / MTHI-MTLO source
- B  input  WIDTH  divisor
- Mult_Wr  input  1  capture ALU product into HI/LO
- ALU_Hi  input  WIDTH  product upper half from ALU
- ALU_Lo  input  WIDTH  product lower half from ALU
- Busy  output  1  divide in progress
- Done  output  1  one-cycle pulse: HI/LO hold the divide result
- DivZero  output  1  pulses with Done when B was zero
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: HI=0, LO=0, Busy=0, Done=0, DivZero=0; state IDLE; internal remainder, quotient and count cleared.
- Reset mid-divide aborts immediately; no partial result is written.
- States: IDLE, DIV, FIN.
- IDLE, Start=1, Op=DIV/DIVU, B!=0:
  - Latch |A| and |B| (raw values for DIVU); record sign(A) and sign(A)^sign(B).
  - Clear remainder and set count=0; go to DIV. Busy=1 from the next cycle.
- DIV: one restoring step per cycle.
  - Shift {rem, quo} left by 1, trial-subtract divisor, set quotient bit.
  - count increments; after step WIDTH-1, go to FIN.
- FIN:
  - LO = quotient, negated if the sign flag is set.
  - HI = remainder, negated if the dividend was negative.
  - Done=1 for exactly one cycle; Busy=0 in that cycle; return to IDLE.
- Latency: Start sampled at edge E0, iterations at E1..E32, write at E33, Done high during the cycle after E33 (WIDTH+1 edges).
- A new Start is accepted in the Done cycle.
- Divide by zero (B==0 at Start):
  - Skip DIV and write at E1: HI=A, LO=all ones.
  - Done=1 and DivZero=1 in the following cycle; Busy high for that single cycle only.
- Signed overflow (0x80000000 / 0xFFFFFFFF): falls out of the unsigned magnitude path as LO=0x80000000, HI=0. No flag.
- MTHI/MTLO (Start=1 in IDLE): HI or LO = A at the same edge. No Busy, no Done.
- Mult_Wr in IDLE with Start=0: HI=ALU_Hi, LO=ALU_Lo at the edge.
- Priority in IDLE: Start beats Mult_Wr.
- Start and Mult_Wr asserted while Busy or in FIN are ignored and not queued.
- Start with an unsupported condition: none. All four Op codes are defined.
- HI/LO are stable during DIV; old values stay readable until FIN writes.

Optional Feature:
- HILO_FWD_EN defined:
  - HI/LO outputs combinationally bypass the value being written this cycle for Mult_Wr and MTHI/MTLO, so a same-cycle MFHI/MFLO sees new data.
  - The divide result is not bypassed; it is visible with Done as before.
- Undefined: HI/LO are pure register outputs; writes are visible the cycle after the edge.

Test Plan:
- DIVU A=100, B=7 -> Done 33 cycles after Start edge; LO=14, HI=2; Busy high 32 cycles; DivZero=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; Done at 33 cycles.
- DIV A=0x1234, B=0 -> Done and DivZero one cycle after the write edge; HI=0x1234, LO=0xFFFFFFFF.
- Mult_Wr with ALU_Hi=0x1, ALU_Lo=0x2 in IDLE -> HI=1, LO=2 next cycle. Mult_Wr=1 with ALU_Hi=0x5 during Busy -> HI/LO unchanged.
- DIVU started, rst_n low at iteration 10 -> HI=LO=0, Busy=0 immediately. After release, DIVU 9/3 -> LO=3, HI=0.
